// File: rtl/mux_rr_arbiter_4_pkg.sv
// Shared constants and the round-robin priority search for mux_rr_arbiter_4.
package mux_rr_arbiter_4_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Pointer holds the last winner; 3 makes requester 0 first after reset.
    localparam logic [1:0] PTR_RESET = 2'd3;

    localparam int DATA_W_DEF = 5;

    typedef struct packed {
        logic [1:0] w;
        logic       any;
    } rr_pick_t;

    // Search ptr+1, ptr+2, ptr+3, ptr+4 (mod 4); the nearest asserted req wins.
    function automatic rr_pick_t rr_pick(input logic [1:0] ptr, input logic [3:0] req);
        rr_pick_t   r;
        logic [1:0] idx;
        r.w   = 2'd0;
        r.any = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                r.w   = idx;
                r.any = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_4to1_5.sv
// Plain 4:1 mux of 5-bit operands.
module mux_4to1_5 (
    input  logic [4:0] d0,
    input  logic [4:0] d1,
    input  logic [4:0] d2,
    input  logic [4:0] d3,
    input  logic [1:0] s,
    output logic [4:0] y
);

    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/mux_rr_arbiter_4.sv
// Round-robin arbiter sharing one multi-cycle resource among 4 requesters;
// holds the grant from START until res_ready or an optional WAIT timeout.
module mux_rr_arbiter_4
    import mux_rr_arbiter_4_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 0,
    parameter int CNT_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] mdata0,
    input  logic [DATA_W-1:0] mdata1,
    input  logic [DATA_W-1:0] mdata2,
    input  logic [DATA_W-1:0] mdata3,
    input  logic              res_ready,
    output logic [1:0]        sel,
    output logic [3:0]        grant,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy,
    output logic              timeout_err
);

    localparam int NSLICE = (DATA_W + 4) / 5;
    localparam int PW     = NSLICE * 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        grant_q, grant_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    rr_pick_t          pick;
    logic [PW-1:0]     pad0, pad1, pad2, pad3, mux_y_pad;
    logic [DATA_W-1:0] mux_y;

    assign pick = rr_pick(ptr_q, req);

    // Payloads are zero-padded to whole 5-bit slices so any DATA_W reuses the same mux.
    assign pad0  = PW'(mdata0);
    assign pad1  = PW'(mdata1);
    assign pad2  = PW'(mdata2);
    assign pad3  = PW'(mdata3);
    assign mux_y = mux_y_pad[DATA_W-1:0];

    for (genvar g = 0; g < NSLICE; g++) begin : g_mux
        mux_4to1_5 u_mux (
            .d0 (pad0[g*5 +: 5]),
            .d1 (pad1[g*5 +: 5]),
            .d2 (pad2[g*5 +: 5]),
            .d3 (pad3[g*5 +: 5]),
            .s  (pick.w),
            .y  (mux_y_pad[g*5 +: 5])
        );
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        sel_d         = sel_q;
        grant_d       = grant_q;
        out_d         = out_q;
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick.any) begin
                    sel_d   = pick.w;
                    grant_d = 4'b0001 << pick.w;
                    out_d   = mux_y;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // Completion takes priority over a timeout expiring in the same cycle.
                if (res_ready) begin
                    grant_d = 4'b0000;
                    ptr_d   = sel_q;
                    state_d = ST_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    grant_d       = 4'b0000;
                    ptr_d         = sel_q;
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= PTR_RESET;
            sel_q         <= 2'd0;
            grant_q       <= 4'b0000;
            out_q         <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            sel_q         <= sel_d;
            grant_q       <= grant_d;
            out_q         <= out_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    assign sel         = sel_q;
    assign grant       = grant_q;
    assign out         = out_q;
    assign out_valid   = (state_q == ST_START);
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mux_rr_arbiter_4.sv
// Directed bench: one arbiter with TIMEOUT=4 and one with the timeout disabled share all inputs.
module tb_mux_rr_arbiter_4;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [4:0] mdata0, mdata1, mdata2, mdata3;
    logic       res_ready;

    logic [1:0] sel, sel_nt;
    logic [3:0] grant, grant_nt;
    logic [4:0] out, out_nt;
    logic       out_valid, out_valid_nt;
    logic       busy, busy_nt;
    logic       timeout_err, timeout_err_nt;

    int checks = 0;
    int errors = 0;

    logic [4:0] mdata_tab [4];

    mux_rr_arbiter_4 #(.DATA_W(5), .TIMEOUT(4), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .mdata0      (mdata0),
        .mdata1      (mdata1),
        .mdata2      (mdata2),
        .mdata3      (mdata3),
        .res_ready   (res_ready),
        .sel         (sel),
        .grant       (grant),
        .out         (out),
        .out_valid   (out_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    mux_rr_arbiter_4 #(.DATA_W(5), .TIMEOUT(0), .CNT_W(8)) dut_nt (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .mdata0      (mdata0),
        .mdata1      (mdata1),
        .mdata2      (mdata2),
        .mdata3      (mdata3),
        .res_ready   (res_ready),
        .sel         (sel_nt),
        .grant       (grant_nt),
        .out         (out_nt),
        .out_valid   (out_valid_nt),
        .busy        (busy_nt),
        .timeout_err (timeout_err_nt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transaction on the TIMEOUT=4 instance with res_ready in the 1st WAIT cycle.
    task automatic run_txn(input logic [3:0] r, input int w, input string tag);
        req = r;
        step();
        req = 4'b0000;
        check({tag, "_sel"}, 32'(sel), 32'(w));
        check({tag, "_grant"}, 32'(grant), 32'(4'b0001 << w));
        check({tag, "_out"}, 32'(out), 32'(mdata_tab[w]));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, "_end_grant"}, 32'(grant), 32'd0);
        check({tag, "_end_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        mdata_tab[0] = 5'd7;
        mdata_tab[1] = 5'd12;
        mdata_tab[2] = 5'd19;
        mdata_tab[3] = 5'd30;
        mdata0 = mdata_tab[0];
        mdata1 = mdata_tab[1];
        mdata2 = mdata_tab[2];
        mdata3 = mdata_tab[3];
        reset = 1'b1;
        req = 4'b0000;
        res_ready = 1'b0;
        step();
        step();
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_out", 32'(out), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_nt_busy", 32'(busy_nt), 32'd0);
        reset = 1'b0;

        // Single requester 0, completion in the 2nd WAIT cycle.
        step();
        check("t1_idle_out_valid", 32'(out_valid), 32'd0);
        req = 4'b0001;
        step();
        req = 4'b0000;
        check("t1_start_grant", 32'(grant), 32'd1);
        check("t1_start_sel", 32'(sel), 32'd0);
        check("t1_start_out", 32'(out), 32'd7);
        check("t1_start_out_valid", 32'(out_valid), 32'd1);
        check("t1_start_busy", 32'(busy), 32'd1);
        check("t1_nt_grant", 32'(grant_nt), 32'd1);
        step();
        check("t1_w1_out_valid", 32'(out_valid), 32'd0);
        check("t1_w1_busy", 32'(busy), 32'd1);
        check("t1_w1_grant", 32'(grant), 32'd1);
        step();
        check("t1_w2_busy", 32'(busy), 32'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t1_end_busy", 32'(busy), 32'd0);
        check("t1_end_grant", 32'(grant), 32'd0);
        check("t1_end_sel", 32'(sel), 32'd0);
        check("t1_end_out", 32'(out), 32'd7);
        check("t1_end_timeout_err", 32'(timeout_err), 32'd0);
        check("t1_nt_end_busy", 32'(busy_nt), 32'd0);
        // ptr is now 0: order 1,2,3,0 so requester 2 beats 0.
        run_txn(4'b0101, 2, "t1_ptr0");

        // All four requesting continuously from reset: strict rotation.
        reset = 1'b1;
        step();
        reset = 1'b0;
        req = 4'b1111;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_start_sel", 32'(sel), 32'(i % 4));
            check("t2_start_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
            check("t2_start_out", 32'(out), 32'(mdata_tab[i % 4]));
            check("t2_start_out_valid", 32'(out_valid), 32'd1);
            step();
            check("t2_wait_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
            check("t2_wait_out_valid", 32'(out_valid), 32'd0);
            step();
            check("t2_idle_grant", 32'(grant), 32'd0);
            check("t2_idle_busy", 32'(busy), 32'd0);
        end
        req = 4'b0000;
        res_ready = 1'b0;

        // ptr=0 -> serve 1 to reach ptr=1, then 0011 gives 0 then 1.
        run_txn(4'b0010, 1, "t3_setup");
        run_txn(4'b0011, 0, "t3_first");
        run_txn(4'b0011, 1, "t3_second");

        // Timeout: requester 2, no res_ready.
        req = 4'b0100;
        step();
        req = 4'b0000;
        check("t4_start_sel", 32'(sel), 32'd2);
        check("t4_start_grant", 32'(grant), 32'd4);
        check("t4_start_out", 32'(out), 32'd19);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t4_wait_busy", 32'(busy), 32'd1);
            check("t4_wait_timeout_err", 32'(timeout_err), 32'd0);
            check("t4_wait_grant", 32'(grant), 32'd4);
        end
        step();
        check("t4_to_timeout_err", 32'(timeout_err), 32'd1);
        check("t4_to_grant", 32'(grant), 32'd0);
        check("t4_to_busy", 32'(busy), 32'd0);
        check("t4_to_out_valid", 32'(out_valid), 32'd0);
        check("t4_to_sel", 32'(sel), 32'd2);
        check("t4_nt_busy", 32'(busy_nt), 32'd1);
        check("t4_nt_grant", 32'(grant_nt), 32'd4);
        check("t4_nt_timeout_err", 32'(timeout_err_nt), 32'd0);
        step();
        check("t4_pulse_once", 32'(timeout_err), 32'd0);
        // ptr=2: order 3,0,1,2 so 0 beats 2 in 0101.
        req = 4'b0101;
        step();
        req = 4'b0000;
        check("t4_ptr2_sel", 32'(sel), 32'd0);
        for (int i = 0; i < 5; i++) step();
        check("t4_ptr2_timeout_err", 32'(timeout_err), 32'd1);
        check("t4_ptr2_nt_grant", 32'(grant_nt), 32'd4);

        // Reset while the no-timeout instance sits in WAIT with grant 0100.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_nt_grant", 32'(grant_nt), 32'd0);
        check("t6_nt_sel", 32'(sel_nt), 32'd0);
        check("t6_nt_out", 32'(out_nt), 32'd0);
        check("t6_nt_busy", 32'(busy_nt), 32'd0);
        check("t6_nt_out_valid", 32'(out_valid_nt), 32'd0);
        check("t6_nt_timeout_err", 32'(timeout_err_nt), 32'd0);
        check("t6_out", 32'(out), 32'd0);
        req = 4'b1001;
        step();
        req = 4'b0000;
        check("t6_grant", 32'(grant), 32'd1);
        check("t6_nt_grant_after", 32'(grant_nt), 32'd1);
        check("t6_nt_sel_after", 32'(sel_nt), 32'd0);
        step();
        step();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t6_end_grant", 32'(grant), 32'd0);
        check("t6_nt_end_grant", 32'(grant_nt), 32'd0);

        // Completion in the 4th WAIT cycle, as the timeout would expire.
        req = 4'b0100;
        step();
        req = 4'b0000;
        check("t5_start_sel", 32'(sel), 32'd2);
        for (int i = 0; i < 4; i++) step();
        check("t5_w4_busy", 32'(busy), 32'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t5_end_grant", 32'(grant), 32'd0);
        check("t5_end_busy", 32'(busy), 32'd0);
        check("t5_end_timeout_err", 32'(timeout_err), 32'd0);
        check("t5_nt_end_busy", 32'(busy_nt), 32'd0);
        step();
        check("t5_after_timeout_err", 32'(timeout_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter_4.md
Name: mux_rr_arbiter_4

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle resource among 4 requesters.
- The resource is, for example, the register-file write-address path or the mult/div unit. Each requester presents a 5-bit payload, such as a register address.
- The block selects one requester, drives the 4:1 5-bit mux select, and captures the chosen payload into a registered output.
- It holds the grant until the resource signals completion, with an optional timeout.

Parameters:
- DATA_W, 5: payload width per requester.
- TIMEOUT, 0: maximum WAIT cycles before abort. 0 disables the timeout.
- CNT_W, 8: width of the timeout counter. Must satisfy TIMEOUT < 2^CNT_W.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  request per requester. Level; a requester holds it until its grant is seen.
- mdata0  in  DATA_W  payload of requester 0.
- mdata1  in  DATA_W  payload of requester 1.
- mdata2  in  DATA_W  payload of requester 2.
- mdata3  in  DATA_W  payload of requester 3.
- res_ready  in  1  resource completion pulse.
- sel  out  2  encoded index of the current or last winner (the mux select).
- grant  out  4  one-hot grant, held for the whole transaction.
- out  out  DATA_W  registered payload of the winner.
- out_valid  out  1  one-cycle start strobe to the resource.
- busy  out  1  high in the START and WAIT states.
- timeout_err  out  1  one-cycle pulse when a transaction is aborted by timeout.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, ptr=2'd3, sel=0, grant=0, out=0, out_valid=0, busy=0, timeout_err=0, cnt=0.
  - ptr=3 means requester 0 has first priority after reset.
- States: IDLE, START, WAIT.
- IDLE:
  - If req==0: remain in IDLE, all strobes low.
  - Otherwise pick the winner w by searching in order ptr+1, ptr+2, ptr+3, ptr+4 (mod 4). The first asserted req wins.
  - Next edge: sel<=w, grant<=onehot(w), out<=mdata[w] (sampled in this IDLE cycle), state<=START.
- START (exactly 1 cycle):
  - out_valid=1, busy=1.
  - res_ready is ignored in this state.
  - Next edge: state<=WAIT, cnt<=0.
- WAIT:
  - busy=1; grant and out are held.
  - If res_ready=1, next edge: grant<=0, ptr<=sel, state<=IDLE. sel and out keep their last values.
  - Else if TIMEOUT!=0 and cnt==TIMEOUT-1, next edge: grant<=0, ptr<=sel, state<=IDLE, timeout_err pulses for 1 cycle (the first IDLE cycle).
  - Else cnt<=cnt+1.
- Throughput:
  - Minimum transaction is 3 cycles: IDLE arbitration, START, 1 WAIT cycle.
  - There is always at least 1 IDLE cycle between grants, which is the cycle in which arbitration happens.
- Requester drops req after being granted: the transaction continues to completion. Grant is committed once issued.
- Requester drops req in the same IDLE cycle: only that cycle's req value matters.
- res_ready with TIMEOUT expiring in the same cycle: completion wins and timeout_err stays 0.
- res_ready while in IDLE: ignored.
- Reset asserted mid-transaction: all state returns to the reset values on the next edge. No out_valid or timeout_err is emitted.
- Fairness: a continuously requesting set is served in strict rotation. Each requester waits at most 3 transactions.
- Output invariants:
  - grant is one-hot or zero.
  - out_valid and timeout_err are never high together.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_START=2'd1, ST_WAIT=2'd2;
  - PTR_RESET=2'd3;
  - DATA_W default.
- Sub-module: instantiate the team's existing 4:1 5-bit mux, mux_4to1_5, to select mdata0..3 using the combinational winner index w.
  - Its output is registered into out.
  - For DATA_W!=5, use a generate-replicated equivalent.
- Round-robin priority search: a small combinational function in the package (ptr, req -> w, any).

Test Plan:
1. Reset, then req=4'b0001, mdata0=5'd7, res_ready pulsed in the 2nd WAIT cycle -> grant=0001, sel=0, out=7. out_valid high exactly 1 cycle, 1 cycle after the req cycle. busy for 3 cycles, then IDLE with ptr=0.
2. req=4'b1111 held constant with res_ready=1 in every WAIT cycle -> winners 0,1,2,3,0 in that order. Each grant lasts 2 cycles, separated by 1 IDLE cycle.
3. ptr=1 with req=4'b0011 -> winner 0 (search order 2,3,0,1). Next arbitration with the same req -> winner 1.
4. TIMEOUT=4, grant requester 2 (mdata2=5'd19), never assert res_ready -> exactly 4 WAIT cycles, timeout_err pulses once, grant=0, ptr=2.
5. TIMEOUT=4 with res_ready in the 4th WAIT cycle -> clean completion, timeout_err=0.
6. Reset asserted during WAIT with grant=0100 -> next cycle all outputs are 0, ptr=3. A subsequent req=4'b1001 grants requester 0 first.
